excp_trap_ctrl: RTL and testbench

Parametrised, registered exception arbiter and trap-handoff controller for the commit stage. It merges a vector of per-cause exception requests with ebreak/ecall decoding. It picks the highest-priority cause, latches cause/tval/epc and offers them to the CSR/trap unit with a valid/ready handshake. After acceptance it issues a one-cycle pipeline flush and a programmable blanking window. It sits between the EXU/IFU exception sources and the CSR block, and replaces purely combinational cause encoding with a held, back-pressured trap record.

---
 rtl/excp_trap_ctrl.sv | 89 ++++++++
 tb/tb_excp_trap_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/excp_trap_ctrl.sv
// excp_trap_ctrl: exception priority arbiter holding a trap record for the CSR unit, then flushing and blanking
module excp_trap_ctrl #(
    parameter int XLEN       = 32,
    parameter int NSRC       = 16,
    parameter int EBRK_CAUSE = 3,
    parameter int ECALL_BASE = 8,
    parameter int BLANK_CYC  = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             excp_i_valid,
    input  logic [NSRC-1:0]  excp_i_src,
    input  logic             excp_i_ebreak,
    input  logic             excp_i_ecall,
    input  logic [1:0]       excp_i_priv,
    input  logic [XLEN-1:0]  excp_i_tval,
    input  logic [XLEN-1:0]  excp_i_pc,
    input  logic             dbg_ebreakm_r,
    input  logic             dbg_mode,
    output logic             excp_o_ready,
    output logic             trap_o_valid,
    input  logic             trap_i_ready,
    output logic [XLEN-1:0]  trap_o_cause,
    output logic [XLEN-1:0]  trap_o_tval,
    output logic [XLEN-1:0]  trap_o_epc,
    output logic             trap_o_dbg,
    output logic             flush_o_req,
    output logic             err_o_overrun,
    output logic [CNT_W-1:0] cnt_o_traps
);
    localparam int BW = $clog2(BLANK_CYC + 1);
    typedef enum logic [1:0] {IDLE, PEND, BLANK} state_t;
    state_t state, state_nx;
    logic [NSRC-1:0] req_vec;
    logic ebreak4excp, ebreak4dbg, hit, dbg_sel;
    logic [XLEN-1:0] cause_sel;
    logic [BW-1:0] blank_cnt;
    always_comb begin
        ebreak4excp = excp_i_ebreak & (~dbg_ebreakm_r | dbg_mode);
        for (int i = 0; i < NSRC; i++)
            req_vec[i] = excp_i_src[i] | (ebreak4excp && i == EBRK_CAUSE)
                       | (excp_i_ecall && i == ECALL_BASE + int'(excp_i_priv));
        ebreak4dbg = excp_i_ebreak & dbg_ebreakm_r & ~dbg_mode & ~|req_vec;
        hit = excp_i_valid & (|req_vec | ebreak4dbg);
        dbg_sel = ~|req_vec;
        cause_sel = XLEN'(EBRK_CAUSE);
        for (int i = NSRC - 1; i >= 0; i--)
            if (req_vec[i]) cause_sel = XLEN'(i);
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = hit ? PEND : IDLE;
            PEND:    state_nx = trap_i_ready ? BLANK : PEND;
            default: state_nx = (blank_cnt == BW'(1)) ? IDLE : BLANK;
        endcase
        excp_o_ready = state == IDLE;
        trap_o_valid = state == PEND;
        flush_o_req  = state == BLANK && blank_cnt == BW'(BLANK_CYC);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            trap_o_cause  <= '0;
            trap_o_tval   <= '0;
            trap_o_epc    <= '0;
            trap_o_dbg    <= 1'b0;
            blank_cnt     <= '0;
            err_o_overrun <= 1'b0;
            cnt_o_traps   <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && hit) begin
                trap_o_cause <= cause_sel;
                trap_o_tval  <= excp_i_tval;
                trap_o_epc   <= excp_i_pc;
                trap_o_dbg   <= dbg_sel;
            end
            if (state == PEND && trap_i_ready) begin
                cnt_o_traps <= cnt_o_traps + CNT_W'(1);
                blank_cnt   <= BW'(BLANK_CYC);
            end else if (state == BLANK) begin
                blank_cnt <= blank_cnt - BW'(1);
            end
            if (state != IDLE && hit) err_o_overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_excp_trap_ctrl.sv
// tb_excp_trap_ctrl: directed stimulus against a cycle-level behavioural model of the trap controller
module tb_excp_trap_ctrl;
    localparam int BLANK = 2;
    logic clk = 0, rst = 1;
    logic excp_i_valid = 0, excp_i_ebreak = 0, excp_i_ecall = 0;
    logic [15:0] excp_i_src = 0;
    logic [1:0] excp_i_priv = 0;
    logic [31:0] excp_i_tval = 0, excp_i_pc = 0;
    logic dbg_ebreakm_r = 0, dbg_mode = 0, trap_i_ready = 0;
    logic excp_o_ready, trap_o_valid, trap_o_dbg, flush_o_req, err_o_overrun;
    logic [31:0] trap_o_cause, trap_o_tval, trap_o_epc;
    logic [1:0] cnt_o_traps;
    int nvec = 0, nerr = 0;
    bit go = 0;

    excp_trap_ctrl #(.XLEN(32), .NSRC(16), .EBRK_CAUSE(3), .ECALL_BASE(8),
                     .BLANK_CYC(BLANK), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .excp_i_valid(excp_i_valid), .excp_i_src(excp_i_src),
        .excp_i_ebreak(excp_i_ebreak), .excp_i_ecall(excp_i_ecall), .excp_i_priv(excp_i_priv),
        .excp_i_tval(excp_i_tval), .excp_i_pc(excp_i_pc), .dbg_ebreakm_r(dbg_ebreakm_r),
        .dbg_mode(dbg_mode), .excp_o_ready(excp_o_ready), .trap_o_valid(trap_o_valid),
        .trap_i_ready(trap_i_ready), .trap_o_cause(trap_o_cause), .trap_o_tval(trap_o_tval),
        .trap_o_epc(trap_o_epc), .trap_o_dbg(trap_o_dbg), .flush_o_req(flush_o_req),
        .err_o_overrun(err_o_overrun), .cnt_o_traps(cnt_o_traps));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pending record flag plus remaining blanking cycles; expected cause is the minimum requested index.
    bit m_pend = 0, m_first = 0, m_err = 0, m_dbg = 0;
    int m_blank = 0, m_cnt = 0, m_cause = 0;
    logic [31:0] m_tval = 0, m_epc = 0;

    function automatic void decode(output bit h, output int c, output bit d);
        int best = 99;
        for (int i = 0; i < 16; i++) if (excp_i_src[i] && i < best) best = i;
        if (excp_i_ebreak && (!dbg_ebreakm_r || dbg_mode) && 3 < best) best = 3;
        if (excp_i_ecall && 8 + int'(excp_i_priv) < best) best = 8 + int'(excp_i_priv);
        h = 0; c = 0; d = 0;
        if (best != 99) begin
            h = excp_i_valid; c = best;
        end else if (excp_i_ebreak && dbg_ebreakm_r && !dbg_mode) begin
            h = excp_i_valid; c = 3; d = 1;
        end
    endfunction

    always @(posedge clk) begin
        bit h, d;
        int c;
        decode(h, c, d);
        m_first = 0;
        if (rst) begin
            m_pend = 0; m_blank = 0; m_err = 0; m_cnt = 0;
            m_cause = 0; m_tval = 0; m_epc = 0; m_dbg = 0;
        end else if (m_pend) begin
            if (h) m_err = 1;
            if (trap_i_ready) begin
                m_pend = 0; m_blank = BLANK; m_cnt = (m_cnt + 1) % 4; m_first = 1;
            end
        end else if (m_blank > 0) begin
            if (h) m_err = 1;
            m_blank--;
        end else if (h) begin
            m_pend = 1; m_cause = c; m_dbg = d; m_tval = excp_i_tval; m_epc = excp_i_pc;
        end
    end

    always @(negedge clk) if (go) begin
        chk("ready", 32'(excp_o_ready), 32'(!m_pend && m_blank == 0));
        chk("valid", 32'(trap_o_valid), 32'(m_pend));
        chk("flush", 32'(flush_o_req), 32'(m_first));
        chk("overrun", 32'(err_o_overrun), 32'(m_err));
        chk("cnt", 32'(cnt_o_traps), 32'(m_cnt));
        if (m_pend) begin
            chk("cause", trap_o_cause, 32'(m_cause));
            chk("tval", trap_o_tval, m_tval);
            chk("epc", trap_o_epc, m_epc);
            chk("dbg", 32'(trap_o_dbg), 32'(m_dbg));
        end
    end

    // Drive one slot for a single cycle; returns 1 ns into the following cycle.
    task automatic slot(input logic [15:0] src, input logic ebk, input logic ecl,
                        input logic [1:0] priv, input logic [31:0] tval, input logic [31:0] pc);
        excp_i_valid = 1; excp_i_src = src; excp_i_ebreak = ebk; excp_i_ecall = ecl;
        excp_i_priv = priv; excp_i_tval = tval; excp_i_pc = pc;
        @(posedge clk); #1;
        excp_i_valid = 0; excp_i_src = 0; excp_i_ebreak = 0; excp_i_ecall = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!excp_o_ready && n < 20) begin
            @(negedge clk); n++;
        end
        if (!excp_o_ready) chk("idle_timeout", 32'(excp_o_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic one(input logic [15:0] src, input logic ebk, input logic ecl,
                       input logic [1:0] priv, input int cause, input bit dbg);
        slot(src, ebk, ecl, priv, 32'h55, 32'h1000);
        @(negedge clk);
        chk("lit_cause", trap_o_cause, 32'(cause));
        chk("lit_dbg", 32'(trap_o_dbg), 32'(dbg));
        wait_idle();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 0; go = 1;
        @(negedge clk);
        chk("rst_ready", 32'(excp_o_ready), 32'd1);
        chk("rst_valid", 32'(trap_o_valid), 32'd0);
        chk("rst_cause", trap_o_cause, 32'd0);
        chk("rst_cnt", 32'(cnt_o_traps), 32'd0);
        @(posedge clk); #1;
        trap_i_ready = 1;
        slot(16'h0010, 0, 1, 2'd3, 32'h100, 32'h200);
        @(negedge clk);
        chk("t1_valid", 32'(trap_o_valid), 32'd1);
        chk("t1_cause", trap_o_cause, 32'd4);
        @(negedge clk);
        chk("t1_valid_fall", 32'(trap_o_valid), 32'd0);
        chk("t1_flush", 32'(flush_o_req), 32'd1);
        chk("t1_ready_lo1", 32'(excp_o_ready), 32'd0);
        chk("t1_cnt", 32'(cnt_o_traps), 32'd1);
        @(negedge clk);
        chk("t1_flush_end", 32'(flush_o_req), 32'd0);
        chk("t1_ready_lo2", 32'(excp_o_ready), 32'd0);
        @(negedge clk);
        chk("t1_ready_back", 32'(excp_o_ready), 32'd1);
        @(posedge clk); #1;
        dbg_ebreakm_r = 1;
        one(16'h0000, 1, 0, 2'd0, 3, 1);
        one(16'h0004, 1, 0, 2'd0, 2, 0);
        dbg_mode = 1;
        one(16'h0000, 1, 0, 2'd0, 3, 0);
        dbg_mode = 0; dbg_ebreakm_r = 0;
        one(16'h0000, 0, 1, 2'd0, 8, 0);
        one(16'h0000, 0, 1, 2'd1, 9, 0);
        one(16'h0000, 0, 1, 2'd3, 11, 0);
        trap_i_ready = 0;
        slot(16'h0020, 0, 0, 2'd0, 32'hDEADBEEF, 32'h8000_0040);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(trap_o_valid), 32'd1);
            chk("hold_tval", trap_o_tval, 32'hDEADBEEF);
            chk("hold_cause", trap_o_cause, 32'd5);
        end
        @(posedge clk); #1;
        slot(16'h0001, 0, 0, 2'd0, 32'h1, 32'h2);
        @(negedge clk);
        chk("ovr_err", 32'(err_o_overrun), 32'd1);
        chk("ovr_cause", trap_o_cause, 32'd5);
        chk("ovr_epc", trap_o_epc, 32'h8000_0040);
        @(posedge clk); #1 trap_i_ready = 1;
        wait_idle();
        trap_i_ready = 0;
        slot(16'h0100, 0, 0, 2'd0, 32'h7, 32'h8);
        @(negedge clk);
        chk("rp_valid", 32'(trap_o_valid), 32'd1);
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("rp_valid0", 32'(trap_o_valid), 32'd0);
        chk("rp_ready1", 32'(excp_o_ready), 32'd1);
        chk("rp_noflush", 32'(flush_o_req), 32'd0);
        chk("rp_err0", 32'(err_o_overrun), 32'd0);
        @(posedge clk); #1 trap_i_ready = 1;
        for (int k = 1; k <= 4; k++) begin
            slot(16'h0080, 0, 0, 2'd0, 32'(k), 32'(k * 4));
            @(negedge clk); @(negedge clk);
            chk("wrap_cnt", 32'(cnt_o_traps), 32'(k % 4));
            wait_idle();
        end
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
